// File: rtl/wishbone_host_master.sv
// Host-command to Wishbone classic master: single writes, read bursts, per-beat timeout,
// and autonomous interrupt-word fetch on a rising edge of the interconnect interrupt.
module wishbone_host_master #(
    parameter int          TIMEOUT  = 1000,
    parameter logic [31:0] INT_ADDR = 32'hFF000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [7:0]  cmd_count,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        rsp_last,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_int_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        int_q, int_d;
    logic        int_pending_q, int_pending_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  remaining_q, remaining_d;
    logic        is_int_q, is_int_d;
    logic [15:0] timer_q, timer_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        timeout_q, timeout_d;

    logic        int_edge;
    logic        launch_int;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            int_q         <= 1'b0;
            int_pending_q <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            remaining_q   <= '0;
            is_int_q      <= 1'b0;
            timer_q       <= '0;
            rsp_data_q    <= '0;
            timeout_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q       <= state_d;
            int_q         <= int_d;
            int_pending_q <= int_pending_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            remaining_q   <= remaining_d;
            is_int_q      <= is_int_d;
            timer_q       <= timer_d;
            rsp_data_q    <= rsp_data_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        remaining_d   = remaining_q;
        is_int_d      = is_int_q;
        timer_d       = timer_q;
        rsp_data_d    = rsp_data_q;
        timeout_d     = timeout_q;

        int_d         = wb_int_i;
        int_edge      = wb_int_i & ~int_q;
        launch_int    = (state_q == IDLE) & int_pending_q;
        // A new edge arriving in the launch cycle must survive the clear.
        int_pending_d = int_edge | (int_pending_q & ~launch_int);

        unique case (state_q)
            IDLE: begin
                if (int_pending_q) begin
                    state_d     = BUS;
                    we_d        = 1'b0;
                    addr_d      = INT_ADDR;
                    wdata_d     = '0;
                    remaining_d = '0;
                    is_int_d    = 1'b1;
                    timer_d     = '0;
                end else if (cmd_valid) begin
                    state_d     = BUS;
                    we_d        = cmd_write;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_write ? cmd_data : 32'h0;
                    remaining_d = cmd_write ? 8'h00 : cmd_count;
                    is_int_d    = 1'b0;
                    timer_d     = '0;
                end
            end
            BUS: begin
                if (wb_ack_i) begin
                    state_d    = RESP;
                    rsp_data_d = we_q ? 32'h0 : wb_dat_i;
                    timeout_d  = 1'b0;
                end else if (timer_q == TMO_LAST) begin
                    state_d     = RESP;
                    rsp_data_d  = '0;
                    timeout_d   = 1'b1;
                    remaining_d = '0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (remaining_q != 8'h00) begin
                        state_d     = BUS;
                        addr_d      = addr_q + 32'd1;
                        remaining_d = remaining_q - 8'd1;
                        timer_d     = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == IDLE) & ~int_pending_q & ~rst;
        wb_cyc_o   = (state_q == BUS);
        wb_stb_o   = (state_q == BUS);
        wb_sel_o   = (state_q == BUS) ? 4'hF : 4'h0;
        wb_we_o    = (state_q == BUS) & we_q;
        wb_adr_o   = (state_q == BUS) ? addr_q : 32'h0;
        wb_dat_o   = (state_q == BUS) ? wdata_q : 32'h0;
        rsp_valid  = (state_q == RESP);
        rsp_data   = (state_q == RESP) ? rsp_data_q : 32'h0;
        rsp_status = (state_q == RESP) ? {is_int_q, timeout_q} : 2'b00;
        rsp_last   = (state_q == RESP) & (remaining_q == 8'h00);
    end

endmodule

// File: doc/wishbone_host_master.md
Name: wishbone_host_master

Overview:
- Wishbone master that sits directly upstream of the wishbone interconnect and drives its m_* port.
- Converts host commands (single write, or read burst of N+1 words) into Wishbone classic cycles and returns one response per bus beat.
- Enforces a bus timeout on every beat.
- On a rising edge of the interconnect's aggregated interrupt, autonomously reads the interrupt word and forwards it as an unsolicited response.

Parameters:
- TIMEOUT, 1000: cycles with stb high and no ack before the beat is aborted; legal range 1..65535.
- INT_ADDR, 32'hFF000000: address read to fetch interrupt flags; slave select 0xFF falls to the interconnect default.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  start address
- cmd_data  in  32  write data (ignored for reads)
- cmd_count  in  8  read beats minus one; ignored for writes
- rsp_valid  out  1  response present
- rsp_ready  in  1  host accepts response
- rsp_data  out  32  read data; 0 for writes and timeouts
- rsp_status  out  2  bit0 = timeout, bit1 = interrupt response
- rsp_last  out  1  final beat of the command, or interrupt response
- wb_we_o  out  1  to interconnect m_we_i
- wb_cyc_o  out  1  to m_cyc_i
- wb_stb_o  out  1  to m_stb_i
- wb_sel_o  out  4  to m_sel_i
- wb_adr_o  out  32  to m_adr_i
- wb_dat_o  out  32  to m_dat_i
- wb_dat_i  in  32  from m_dat_o
- wb_ack_i  in  1  from m_ack_o
- wb_int_i  in  1  from m_int_o

Behaviour:
- All state is on the clk rising edge; rst is synchronous.
- On rst, every output is 0, the state is IDLE, int_pending = 0, and the registered copy of wb_int_i = 0.
- States: IDLE, BUS, RESP.
- cmd_ready = (state == IDLE) & !int_pending & !rst.
- Interrupt edge detection:
  - A rising edge (wb_int_i & !int_q) in any state sets int_pending.
  - An edge in the same cycle that the IDLE interrupt launch clears int_pending leaves it set.
  - Interrupts are serviced only from IDLE.
- IDLE → BUS, interrupt has priority over commands:
  - If int_pending: clear it and launch a read at INT_ADDR with is_int = 1 and remaining = 0.
  - Else if cmd_valid: latch write, addr, data and remaining = write ? 0 : cmd_count; set is_int = 0.
  - Next cycle: wb_cyc_o = wb_stb_o = 1, wb_sel_o = 4'hF, wb_we_o = latched write, wb_adr_o = current addr, wb_dat_o = data (0 on reads).
- BUS:
  - A 16-bit timer counts cycles with stb high.
  - On wb_ack_i: drop stb, cyc and we the next cycle; capture wb_dat_i (0 on writes); status = {is_int, 0}; go to RESP.
  - If the timer reaches TIMEOUT-1 without ack: drop cyc/stb; rsp_data = 0; status = {is_int, 1}; force remaining = 0; go to RESP.
  - ack in the same cycle as the timeout expiry counts as ack.
- Latency: ack to rsp_valid is 1 cycle; command accept to stb is 1 cycle.
- RESP:
  - rsp_valid = 1, rsp_last = (remaining == 0).
  - Outputs hold stable until rsp_ready.
  - Bus is idle (cyc = 0) while waiting; no transaction is outstanding.
- RESP on handshake:
  - If remaining != 0: addr += 1 (32-bit wrap from FFFFFFFF to 0 is allowed); remaining -= 1; timer clears; go to BUS (stb next cycle).
  - Else go to IDLE; rsp_valid falls the cycle after the handshake.
- The timer clears on every entry to BUS.
- Reset mid-operation: the bus drops immediately the next cycle, pending responses are discarded, and any pending interrupt is lost.
- wb_ack_i while not in BUS is ignored.

Test Plan:
- Reset → all outputs 0; cmd_ready = 1 the cycle after rst falls.
- Write addr 01000004, data DEADBEEF, ack after 2 cycles:
  - wb_adr_o = 01000004, wb_we_o = 1, wb_dat_o = DEADBEEF.
  - Exactly one rsp with status 00, last = 1, data 0.
- Read burst addr 00000010, count 2, slave returns 11/22/33, rsp_ready held low 3 cycles on beat 2:
  - Addresses 10, 11, 12.
  - Three rsps with data 11, 22, 33; last on the third only.
  - cyc low during the stall.
- No ack, TIMEOUT = 8, read burst count 3:
  - stb drops after 8 cycles.
  - A single rsp with status 01, data 0, last = 1; next command accepted.
- wb_int_i rises mid-burst:
  - Burst completes unchanged.
  - Then a read at FF000000 is issued; rsp status 10, last = 1, data = interrupt word.
  - cmd_ready stays 0 until this response is accepted.
- rst asserted while in BUS:
  - The next cycle cyc/stb/rsp_valid = 0, state is IDLE, and no response is emitted.
